// File: rtl/fifo_pkg.sv
// Shared types and defaults for the syn_fifo read-side streamer.
// Contents: default word width, output buffer depth, occupancy state encoding,
// and a helper that turns an occupancy state into an entry count.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_BUF_DEPTH  = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Number of buffered entries represented by an occupancy state.
    function automatic logic [1:0] occ_count(input occ_e occ);
        return 2'(occ);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry output buffer with an occupancy FSM.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   push, din   - write din into the buffer tail
//   pop         - head consumed by the sink this cycle
//   flush       - discard all buffered entries (wins over push/pop)
//   valid, data - registered head of buffer
//   occ         - current occupancy state
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output occ_e                  occ
);

    occ_e                  state;
    occ_e                  state_nxt;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] head_nxt;
    logic [DATA_WIDTH-1:0] tail;
    logic [DATA_WIDTH-1:0] tail_nxt;

    // State and storage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OCC_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
        end
    end

    // Occupancy transitions; head only changes when a new word becomes head.
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        if (flush) begin
            state_nxt = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    // pop cannot occur here: valid is low while empty
                    if (push) begin
                        state_nxt = OCC_ONE;
                        head_nxt  = din;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_nxt = din;
                    end else if (push) begin
                        state_nxt = OCC_TWO;
                        tail_nxt  = din;
                    end else if (pop) begin
                        state_nxt = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // read issue never leaves a word in flight while full,
                    // but keep ordering correct if push and pop coincide
                    if (pop) begin
                        head_nxt = tail;
                        if (push) begin
                            tail_nxt = din;
                        end else begin
                            state_nxt = OCC_ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = OCC_EMPTY;
                end
            endcase
        end
    end

    assign valid = (state != OCC_EMPTY);
    assign data  = head;
    assign occ   = state;

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drain stage for syn_fifo: issues read strobes, absorbs the FIFO's one-cycle
// registered read latency and presents words on a valid/ready stream at up to
// one word per clock. Never strobes an empty FIFO; at most two words are ever
// held outside the FIFO (buffered plus in flight).
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   flush                 - drop buffered and in-flight words, no strobe this cycle
//   fifo_empty, fifo_data - syn_fifo status and read data (valid cycle after strobe)
//   fifo_rd_cs, fifo_rd_en- read strobe (combinational, identical signals)
//   m_valid, m_ready, m_data - output stream
//   word_cnt              - words accepted by the sink (FIFO_RD_STATS_EN only)
// Build option: define FIFO_RD_STATS_EN to add the word_cnt port and counter.
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BUF_DEPTH  = DEF_BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]           word_cnt
`endif
);

    localparam int unsigned OUT_W     = 3;
    localparam logic [OUT_W-1:0] OCC_LIMIT = OUT_W'(BUF_DEPTH);

    occ_e             occ;
    logic             inflight;
    logic             pop;
    logic             push;
    logic             rd;
    logic [OUT_W-1:0] outstanding;

    assign pop  = m_valid && m_ready;
    // A word returning during flush belongs to the discarded stream.
    assign push = inflight && !flush;

    // Words that will sit outside the FIFO after this edge, before any new strobe.
    assign outstanding = OUT_W'(occ_count(occ)) + OUT_W'(inflight) - OUT_W'(pop);
    assign rd = !reset && !fifo_empty && !flush && (outstanding < OCC_LIMIT);

    assign fifo_rd_en = rd;
    assign fifo_rd_cs = rd;

    // One-cycle read latency tracker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd;
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (fifo_data),
        .valid (m_valid),
        .data  (m_data),
        .occ   (occ)
    );

`ifdef FIFO_RD_STATS_EN
    localparam int unsigned CNT_W = 32;
    logic [CNT_W-1:0] word_cnt_q;

    // Accepted-word counter; wraps naturally, flush does not touch it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt_q <= '0;
        end else if (pop) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer with a behavioural syn_fifo read port
// (registered read data, status updated on the strobe edge).
// Build option: define FIFO_RD_STATS_EN to also exercise word_cnt.
module tb_fifo_rd_streamer;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_cs;
    logic       fifo_rd_en;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
`ifdef FIFO_RD_STATS_EN
    logic [31:0] word_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // FIFO model: stimulus writes, model reads
    logic [7:0] fmem [0:63];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic       rd_s   = 1'b0;

    always #5 clk = ~clk;

    fifo_rd_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_cs (fifo_rd_cs),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_RD_STATS_EN
        ,
        .word_cnt   (word_cnt)
`endif
    );

    assign fifo_empty = (wr_cnt == rd_cnt);

    // Strobe sampled mid-cycle, acted on at the next rising edge.
    always @(negedge clk) rd_s <= fifo_rd_en;

    always @(posedge clk) begin
        if (rd_s) begin
            checks++;
            assert (wr_cnt != rd_cnt) else begin
                errors++;
                $error("FAIL read_empty: observed strobe with wr=%0d rd=%0d, expected no strobe", wr_cnt, rd_cnt);
            end
            fifo_data <= fmem[rd_cnt[5:0]];
            rd_cnt    <= rd_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] v);
        fmem[wr_cnt[5:0]] = v;
        wr_cnt++;
    endtask

    initial begin
        reset   = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        #2;
        check("rst_valid", 32'(m_valid), 32'h0);
        check("rst_data", 32'(m_data), 32'h0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'h0);
        check("rst_rd_cs", 32'(fifo_rd_cs), 32'h0);
        step();
        step();
        reset = 1'b0;

        // back-to-back drain at full rate
        m_ready = 1'b1;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        #1;
        check("t1_rd0", 32'(fifo_rd_en), 32'h1);
        step();
        check("t1_rd1", 32'(fifo_rd_en), 32'h1);
        check("t1_v_lat", 32'(m_valid), 32'h0);
        step();
        check("t1_rd2", 32'(fifo_rd_cs), 32'h1);
        check("t1_v0", 32'(m_valid), 32'h1);
        check("t1_d0", 32'(m_data), 32'h11);
        step();
        check("t1_rd3", 32'(fifo_rd_en), 32'h0);
        check("t1_d1", 32'(m_data), 32'h22);
        step();
        check("t1_v2", 32'(m_valid), 32'h1);
        check("t1_d2", 32'(m_data), 32'h33);
        step();
        check("t1_v_end", 32'(m_valid), 32'h0);
        check("t1_strobes", 32'(rd_cnt), 32'd3);

        // backpressure: only two words leave the FIFO
        m_ready = 1'b0;
        push_word(8'h44);
        push_word(8'h55);
        push_word(8'h66);
        push_word(8'h77);
        step();
        step();
        step();
        step();
        check("t2_v_hold", 32'(m_valid), 32'h1);
        check("t2_d_hold", 32'(m_data), 32'h44);
        check("t2_no_rd", 32'(fifo_rd_en), 32'h0);
        check("t2_strobes", 32'(rd_cnt), 32'd5);
        m_ready = 1'b1;
        #1;
        check("t2_rd_on_pop", 32'(fifo_rd_en), 32'h1);
        step();
        check("t2_d1", 32'(m_data), 32'h55);
        step();
        check("t2_d2", 32'(m_data), 32'h66);
        step();
        check("t2_v3", 32'(m_valid), 32'h1);
        check("t2_d3", 32'(m_data), 32'h77);
        step();
        check("t2_v_end", 32'(m_valid), 32'h0);
        check("t2_strobes_all", 32'(rd_cnt), 32'd7);

        // empty FIFO: nothing happens
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_rd", 32'(fifo_rd_en), 32'h0);
            check("t3_v", 32'(m_valid), 32'h0);
        end

        // flush with one buffered word and one in flight
        m_ready = 1'b0;
        push_word(8'h81);
        push_word(8'h82);
        push_word(8'h83);
        push_word(8'h84);
        step();
        step();
        step();
        step();
        check("t4_d_full", 32'(m_data), 32'h81);
        m_ready = 1'b1;
        #1;
        check("t4_rd_pop", 32'(fifo_rd_en), 32'h1);
        step();
        m_ready = 1'b0;
        flush   = 1'b1;
        #1;
        check("t4_d_pre", 32'(m_data), 32'h82);
        check("t4_rd_flush", 32'(fifo_rd_en), 32'h0);
        step();
        flush = 1'b0;
        check("t4_v_flushed", 32'(m_valid), 32'h0);
        m_ready = 1'b1;
        #1;
        check("t4_rd_resume", 32'(fifo_rd_en), 32'h1);
        step();
        check("t4_v_drop", 32'(m_valid), 32'h0);
        step();
        check("t4_v_next", 32'(m_valid), 32'h1);
        check("t4_d_next", 32'(m_data), 32'h84);
        step();
        check("t4_v_end", 32'(m_valid), 32'h0);
        check("t4_strobes", 32'(rd_cnt), 32'd11);

        // asynchronous reset with one buffered word and one in flight
        m_ready = 1'b0;
        push_word(8'h91);
        push_word(8'h92);
        push_word(8'h93);
        step();
        step();
        check("t5_v_pre", 32'(m_valid), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check("t5_v_rst", 32'(m_valid), 32'h0);
        check("t5_d_rst", 32'(m_data), 32'h0);
        check("t5_rd_rst", 32'(fifo_rd_en), 32'h0);
        step();
        step();
        reset   = 1'b0;
        m_ready = 1'b1;
        #1;
        check("t5_rd_post", 32'(fifo_rd_en), 32'h1);
        step();
        check("t5_v_lat", 32'(m_valid), 32'h0);
        step();
        check("t5_v_first", 32'(m_valid), 32'h1);
        check("t5_d_first", 32'(m_data), 32'h93);
        step();
        check("t5_v_end", 32'(m_valid), 32'h0);
        check("t5_strobes", 32'(rd_cnt), 32'd14);

`ifdef FIFO_RD_STATS_EN
        // accepted-word counter and wrap
        reset = 1'b1;
        #1;
        check("s_cnt_rst", word_cnt, 32'h0);
        step();
        reset   = 1'b0;
        m_ready = 1'b1;
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        push_word(8'hA4);
        push_word(8'hA5);
        for (int i = 0; i < 8; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("s_cnt_5", word_cnt, 32'd5);
        m_ready = 1'b0;
        push_word(8'hB1);
        step();
        step();
        step();
        force dut.word_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.word_cnt_q;
        #1;
        check("s_cnt_preset", word_cnt, 32'hFFFF_FFFF);
        m_ready = 1'b1;
        step();
        check("s_cnt_wrap", word_cnt, 32'h0);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
